// File: rtl/rice_pack.sv
// rice_pack: MSB-first packer of variable-length Rice code words into OUT_W-bit words; define RICE_PACK_BITCNT_EN to add the bit_count output
module rice_pack #(
    parameter int OUT_W = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [15:0]      in_code,
    input  logic [4:0]       in_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef RICE_PACK_BITCNT_EN
    output logic [31:0]      bit_count,
`endif
    output logic             flush_done
);
    localparam int BUF_W = OUT_W + 16;
    localparam int CW = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {RUN, DRAIN, PAD, DONE} state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, app;
    logic [CW-1:0]    cnt_q, cnt_d, c1;
    logic [4:0]       len;
    logic [15:0]      mask;
    logic             emit, accept;

    // handshakes and accumulator update: the outgoing word shifts out first, then the new code lands right below the remaining bits
    always_comb begin
        len = (in_len > 5'd16) ? 5'd16 : in_len;
        mask = 16'((17'd1 << len) - 17'd1);
        out_data = buf_q[BUF_W-1 -: OUT_W];
        out_valid = (cnt_q >= CW'(OUT_W)) || (state_q == PAD && cnt_q != '0);
        in_ready = (state_q == RUN) && (cnt_q <= CW'(OUT_W));
        flush_done = (state_q == DONE);
        emit = out_valid && out_ready;
        accept = in_valid && in_ready;
        c1 = !emit ? cnt_q : (cnt_q >= CW'(OUT_W)) ? cnt_q - CW'(OUT_W) : '0;
        app = (BUF_W'(in_code & mask) << (BUF_W - 32'(len))) >> c1;
        buf_d = (emit ? buf_q << OUT_W : buf_q) | (accept ? app : '0);
        cnt_d = c1 + (accept ? CW'(len) : '0);
    end

    // flush sequencing: a pending code goes first, full words drain, the tail is padded, then one done cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = (flush && !in_valid) ? DRAIN : RUN;
            DRAIN:   if (cnt_q < CW'(OUT_W)) state_d = (cnt_q != '0) ? PAD : DONE;
            PAD:     state_d = emit ? DONE : PAD;
            default: state_d = RUN;
        endcase
    end

    // state, accumulator and fill count registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef RICE_PACK_BITCNT_EN
    logic [31:0] bit_count_q, bit_count_d;

    // stream bit total: accepted code bits plus the zero bits added when a padded word leaves
    always_comb begin
        bit_count_d = bit_count_q + (accept ? 32'(len) : 32'd0)
                    + ((state_q == PAD && emit) ? 32'(OUT_W) - 32'(cnt_q) : 32'd0);
    end

    // bit total register, wraps modulo 2^32
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) bit_count_q <= '0;
        else bit_count_q <= bit_count_d;
    end

    assign bit_count = bit_count_q;
`endif
endmodule

// File: tb/tb_rice_pack.sv
// tb_rice_pack: directed scoreboard bench for rice_pack with OUT_W=8
module tb_rice_pack;
    logic        CLK = 0;
    logic        reset = 1;
    logic [15:0] in_code = 0;
    logic [4:0]  in_len = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic        flush = 0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1;
    logic        flush_done;
`ifdef RICE_PACK_BITCNT_EN
    logic [31:0] bit_count;
`endif

    int         checks = 0;
    int         errors = 0;
    int         nfd = 0;
    int         fd0;
    logic [7:0] exp_q[$];
    logic       hold = 0;
    logic [7:0] hd = 0;

    always #5 CLK = ~CLK;

    rice_pack #(.OUT_W(8)) dut (
        .CLK(CLK),
        .reset(reset),
        .in_code(in_code),
        .in_len(in_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef RICE_PACK_BITCNT_EN
        .bit_count(bit_count),
`endif
        .flush_done(flush_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] c, input logic [4:0] l);
        int t = 0;
        logic r;
        in_code = c;
        in_len = l;
        in_valid = 1;
        do begin
            @(negedge CLK);
            r = in_ready;
            @(posedge CLK);
            #1;
            t++;
        end while (!r && t < 100);
        in_valid = 0;
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: code %0h never accepted", c);
        end
    endtask

    task automatic do_flush();
        int t = 0;
        logic d;
        flush = 1;
        do begin
            @(negedge CLK);
            d = flush_done;
            @(posedge CLK);
            #1;
            t++;
        end while (!d && t < 100);
        flush = 0;
        if (!d) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout: got no flush_done expected pulse");
        end
    endtask

    // monitor: pops the scoreboard on every transfer and checks stability while stalled
    initial begin
        forever begin
            @(negedge CLK);
            if (reset) hold = 0;
            else begin
                if (hold) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_data", 32'(out_data), 32'(hd));
                end
                if (flush_done) nfd++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected none", out_data);
                    end else chk("word", 32'(out_data), 32'(exp_q.pop_front()));
                end
                hold = out_valid && !out_ready;
                hd = out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_flush_done", 32'(flush_done), 0);
        reset = 0;

        // two 6-bit codes, flush pads the tail
        exp_q.push_back(8'hE7);
        exp_q.push_back(8'h90);
        send(16'h0039, 5'd6);
        send(16'h0039, 5'd6);
        do_flush();
        chk("t1_drained", 32'(exp_q.size()), 0);
        chk("t1_flush_done", 32'(nfd), 1);
`ifdef RICE_PACK_BITCNT_EN
        chk("t1_bit_count", bit_count, 16);
`endif

        // 16-bit code then 1-bit code
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h80);
        send(16'hFFFE, 5'd16);
        send(16'h0001, 5'd1);
        do_flush();
        chk("t2_drained", 32'(exp_q.size()), 0);
        chk("t2_flush_done", 32'(nfd), 2);

        // backpressure: 2-bit codes while out_ready is low
        out_ready = 0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        repeat (5) send(16'h0003, 5'd2);
        in_code = 16'h0003;
        in_len = 5'd2;
        in_valid = 1;
        repeat (3) begin
            @(negedge CLK);
            chk("t3_in_ready", 32'(in_ready), 0);
            chk("t3_out_valid", 32'(out_valid), 1);
            chk("t3_out_data", 32'(out_data), 32'hFF);
        end
        @(posedge CLK);
        #1;
        out_ready = 1;
        repeat (3) send(16'h0003, 5'd2);
        do_flush();
        chk("t3_drained", 32'(exp_q.size()), 0);
        chk("t3_flush_done", 32'(nfd), 3);

        // zero-length codes and ignored high bits: 101 101 11111
        exp_q.push_back(8'hB7);
        exp_q.push_back(8'hE0);
        send(16'h0005, 5'd3);
        send(16'hFFFF, 5'd0);
        send(16'hFFFD, 5'd3);
        send(16'h0000, 5'd0);
        send(16'h001F, 5'd5);
        do_flush();
        chk("t4_drained", 32'(exp_q.size()), 0);
        chk("t4_flush_done", 32'(nfd), 4);

        // length above 16 is clamped to 16
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        send(16'hA5C3, 5'd20);
        do_flush();
        chk("t5_drained", 32'(exp_q.size()), 0);
        chk("t5_flush_done", 32'(nfd), 5);

        // reset while stalled in PAD
        out_ready = 0;
        send(16'h001F, 5'd5);
        flush = 1;
        repeat (4) @(negedge CLK);
        chk("t6_pad_valid", 32'(out_valid), 1);
        chk("t6_pad_data", 32'(out_data), 32'hF8);
        fd0 = nfd;
        @(posedge CLK);
        #1;
        reset = 1;
        flush = 0;
        #2;
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 1);
        chk("t6_rst_out_data", 32'(out_data), 0);
        chk("t6_rst_flush_done", 32'(flush_done), 0);
        @(posedge CLK);
        #1;
        reset = 0;
        out_ready = 1;
        chk("t6_no_flush_done", 32'(nfd), 32'(fd0));
        exp_q.push_back(8'h80);
        send(16'h0001, 5'd1);
        do_flush();
        chk("t6_drained", 32'(exp_q.size()), 0);
        chk("t6_flush_done", 32'(fd0 + 1), 32'(nfd));

        // flush together with a valid code: code first, no pad word
        fd0 = nfd;
        exp_q.push_back(8'hAB);
        flush = 1;
        send(16'h00AB, 5'd8);
        do_flush();
        repeat (3) @(negedge CLK);
        chk("t7_drained", 32'(exp_q.size()), 0);
        chk("t7_flush_done", 32'(nfd), 32'(fd0 + 1));
        chk("t7_idle_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
